// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake/operand/result bundle for alu_seq.
//   master : issuer side - drives in_valid, op, i0, i1; observes in_ready and results.
//   slave  : ALU side    - consumes operands, drives in_ready, o, cout, zero, out_valid.
// Parameter WIDTH must match the WIDTH of the attached alu_seq.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] o;
  logic             cout;
  logic             zero;
  logic             out_valid;

  modport master (
    output in_valid, op, i0, i1,
    input  in_ready, o, cout, zero, out_valid
  );

  modport slave (
    input  in_valid, op, i0, i1,
    output in_ready, o, cout, zero, out_valid
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready input handshake.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : alu_seq_if.slave - in_valid/in_ready/op/i0/i1 in, o/cout/zero/out_valid out
// Opcodes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 mul.
// Single-cycle ops register their result one clock after transfer.
// Build option ALU_MUL_EN: when defined, op 111 runs an iterative shift-add multiply that
// holds in_ready low for WIDTH clocks. When undefined, op 111 is single-cycle and
// returns o = 0, cout = 0, zero = 1.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);

  localparam int unsigned ShW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpShl = 3'b101,
    OpShr = 3'b110,
    OpMul = 3'b111
  } op_e;

  op_e              op;
  logic             in_ready;
  logic             xfer;
  logic             mul_op;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;
  logic             mul_ovf;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

  logic [WIDTH-1:0] o_q, o_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  assign op   = op_e'(bus.op);
  assign xfer = bus.in_valid && in_ready;

  // Single-cycle datapath
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (op)
      OpAdd:   {alu_c, alu_res} = {1'b0, bus.i0} + {1'b0, bus.i1};
      // Carry out of i0 + ~i1 + 1 is the "no borrow" flag (i0 >= i1).
      OpSub:   {alu_c, alu_res} = {1'b0, bus.i0} + {1'b0, ~bus.i1} + {{WIDTH{1'b0}}, 1'b1};
      OpAnd:   alu_res = bus.i0 & bus.i1;
      OpOr:    alu_res = bus.i0 | bus.i1;
      OpXor:   alu_res = bus.i0 ^ bus.i1;
      OpShl:   alu_res = bus.i0 << bus.i1[ShW-1:0];
      OpShr:   alu_res = bus.i0 >> bus.i1[ShW-1:0];
      OpMul:   alu_res = '0;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    StIdle,
    StMul
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]     psum;
  logic               mul_start;

  assign mul_op    = (op == OpMul);
  assign mul_start = xfer && mul_op;
  assign mul_done  = (state_q == StMul) && (cnt_q == CntW'(WIDTH - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (mul_start) state_d = StMul;
      StMul:   if (mul_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == StIdle) && !reset;
  end

  // Shift-add step: the add's carry becomes the new accumulator MSB after the right shift.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    psum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
    if (mul_start) begin
      mcand_d  = bus.i0;
      mplier_d = bus.i1;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == StMul) begin
      acc_d    = {psum, acc_q[WIDTH-1:1]};
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mul_res = acc_d[WIDTH-1:0];
  assign mul_ovf = |acc_d[2*WIDTH-1:WIDTH];
`else
  // No multiplier: op 111 goes through the single-cycle path and yields zero.
  assign mul_op   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_ovf  = 1'b0;

  always_comb begin
    in_ready = !reset;
  end
`endif

  // Result registers hold until the next result; out_valid is a one-cycle pulse.
  always_comb begin
    o_d     = o_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    if (xfer && !mul_op) begin
      o_d     = alu_res;
      cout_d  = alu_c;
      zero_d  = (alu_res == '0);
      valid_d = 1'b1;
    end else if (mul_done) begin
      o_d     = mul_res;
      cout_d  = mul_ovf;
      zero_d  = (mul_res == '0);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.o         = o_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + randomized bench for alu_seq (WIDTH = 16).
// Works in both builds; multiply expectations follow ALU_MUL_EN.
module tb_alu_seq;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] last_o;
  logic         last_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned arithmetic on wide integers.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c);
    longint unsigned x, y, m, p;
    x = 64'(a);
    y = 64'(b);
    m = 64'd1 << W;
    p = 0;
    c = 1'b0;
    case (op)
      3'd0: begin p = x + y; c = (p >= m); end
      3'd1: begin p = (x + m - y) % m; c = (x >= y); end
      3'd2: p = x & y;
      3'd3: p = x | y;
      3'd4: p = x ^ y;
      3'd5: p = (x << (y % W)) % m;
      3'd6: p = x >> (y % W);
      default: begin
`ifdef ALU_MUL_EN
        p = x * y;
        c = (p >= m);
`else
        p = 0;
`endif
      end
    endcase
    r = W'(p % m);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         c;
    model(op, a, b, r, c);
    chk({tag, ".rdy_in"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.i0       = a;
    bus.i1       = b;
    step();
`ifdef ALU_MUL_EN
    if (op == 3'b111) begin
      // Keep in_valid high with changing inputs: none of it may be taken.
      for (int i = 1; i <= int'(W); i++) begin
        chk({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
        chk({tag, ".nov"}, 32'(bus.out_valid), 32'd0);
        bus.op = 3'($urandom);
        bus.i0 = W'($urandom);
        bus.i1 = W'($urandom);
        step();
      end
    end
`endif
    chk({tag, ".o"}, 32'(bus.o), 32'(r));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(c));
    chk({tag, ".zero"}, 32'(bus.zero), 32'(r == '0));
    chk({tag, ".ov"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".rdy_out"}, 32'(bus.in_ready), 32'd1);
    last_o = r;
    last_c = c;
  endtask

  task automatic idle(input string tag);
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.i0       = W'($urandom);
    step();
    chk({tag, ".ov"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".hold_o"}, 32'(bus.o), 32'(last_o));
    chk({tag, ".hold_c"}, 32'(bus.cout), 32'(last_c));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".o"}, 32'(bus.o), 32'd0);
    chk({tag, ".cout"}, 32'(bus.cout), 32'd0);
    chk({tag, ".zero"}, 32'(bus.zero), 32'd1);
    chk({tag, ".ov"}, 32'(bus.out_valid), 32'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(5))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(W));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = 3'd0;
    bus.i0       = '0;
    bus.i1       = '0;
    last_o       = '0;
    last_c       = 1'b0;

    // Reset held for two cycles
    step();
    step();
    chk("rst.rdy_low", 32'(bus.in_ready), 32'd0);
    chk_reset_vals("rst");
    reset = 1'b0;
    #1;
    chk("rst.rdy_high", 32'(bus.in_ready), 32'd1);

    // Back-to-back adds
    do_op("add_wrap", 3'd0, 16'hffff, 16'h0001);
    do_op("add_ffff", 3'd0, 16'haa55, 16'h55aa);
    idle("idle0");

    do_op("sub_neg", 3'd1, 16'h0001, 16'h7fff);
    do_op("sub_pos", 3'd1, 16'h7fff, 16'h0001);
    do_op("sub_eq", 3'd1, 16'h1234, 16'h1234);
    do_op("and0", 3'd2, 16'haa55, 16'h55aa);
    do_op("or", 3'd3, 16'haa00, 16'h0055);
    do_op("xor", 3'd4, 16'hffff, 16'h0f0f);
    do_op("shl15", 3'd5, 16'h0001, 16'h000f);
    do_op("shr_mask", 3'd6, 16'h8000, 16'h0013);
    idle("idle1");

    do_op("mul_3x5", 3'd7, 16'h0003, 16'h0005);
    do_op("mul_ovf", 3'd7, 16'hffff, 16'h0002);
    do_op("mul_max", 3'd7, 16'hffff, 16'hffff);
    idle("idle2");

`ifdef ALU_MUL_EN
    // Reset during multiply step 8
    bus.in_valid = 1'b1;
    bus.op       = 3'd7;
    bus.i0       = 16'h1234;
    bus.i1       = 16'h5678;
    step();
    bus.in_valid = 1'b0;
    for (int i = 1; i < 8; i++) step();
    reset = 1'b1;
    step();
    chk_reset_vals("rst_mul");
    chk("rst_mul.rdy_low", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_mul.rdy_high", 32'(bus.in_ready), 32'd1);
    last_o = '0;
    last_c = 1'b0;
    for (int i = 0; i < int'(W); i++) idle("rst_mul.quiet");
`endif

    // Reset beats a simultaneous transfer
    do_op("pre_rst", 3'd3, 16'h00f0, 16'h0f00);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 3'd0;
    bus.i0       = 16'h0001;
    bus.i1       = 16'h0001;
    step();
    chk_reset_vals("rst_vs_xfer");
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    last_o       = '0;
    last_c       = 1'b0;
    idle("rst_vs_xfer.after");

    // Randomized traffic with idle gaps
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(3) == 0) idle("rnd_idle");
      else do_op("rnd", 3'($urandom), pick(), pick());
    end
    idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time guard
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
